eq_mac_scheduler: RTL

//  Time-multiplexes one signed multiplier/accumulator across the cascaded low->mid->high biquad bands.

---
 rtl/eq_pkg.sv | 35 +++
 rtl/eq_round_sat.sv | 31 +++
 rtl/eq_mac_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// eq_pkg: shared definitions for the cascaded biquad EQ.
//  - FSM state encoding for eq_mac_scheduler
//  - coefficient fraction width and taps per band
//  - coefficient bank index map (band*5 + tap), shared with the coef bank
package eq_pkg;

  localparam int FRAC          = 14;
  localparam int TAPS_PER_BAND = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    MAC     = 3'd2,
    WB      = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Tap order within a band: b0, b1, b2, a1, a2
  localparam logic [3:0] LOW_B0  = 4'd0;
  localparam logic [3:0] LOW_B1  = 4'd1;
  localparam logic [3:0] LOW_B2  = 4'd2;
  localparam logic [3:0] LOW_A1  = 4'd3;
  localparam logic [3:0] LOW_A2  = 4'd4;
  localparam logic [3:0] MID_B0  = 4'd5;
  localparam logic [3:0] MID_B1  = 4'd6;
  localparam logic [3:0] MID_B2  = 4'd7;
  localparam logic [3:0] MID_A1  = 4'd8;
  localparam logic [3:0] MID_A2  = 4'd9;
  localparam logic [3:0] HIGH_B0 = 4'd10;
  localparam logic [3:0] HIGH_B1 = 4'd11;
  localparam logic [3:0] HIGH_B2 = 4'd12;
  localparam logic [3:0] HIGH_A1 = 4'd13;
  localparam logic [3:0] HIGH_A2 = 4'd14;

endpackage

// File: rtl/eq_round_sat.sv
// eq_round_sat: combinational accumulator -> sample conversion.
//  y = sat_DATA_W((acc + 2^(FRAC-1)) >>> FRAC), round-half-up.
// Ports:
//  acc  in   ACC_W   signed accumulator
//  y    out  DATA_W  signed rounded, saturated sample
module eq_round_sat
  import eq_pkg::*;
#(
  parameter int ACC_W  = 40,
  parameter int DATA_W = 16
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);

  logic signed [ACC_W-1:0] shf;

  // acc is bounded well inside ACC_W, so adding HALF cannot wrap
  assign shf = (acc + HALF) >>> FRAC;

  always_comb begin
    y = shf[DATA_W-1:0];
    if (shf > MAXV)      y = MAXV[DATA_W-1:0];
    else if (shf < MINV) y = MINV[DATA_W-1:0];
  end

endmodule

// File: rtl/eq_mac_scheduler.sv
// eq_mac_scheduler: runs NUM_BANDS cascaded biquads (low->mid->high) on one
// shared signed multiplier/accumulator, once per I2S frame.
// Ports:
//  clk, reset   system clock, synchronous active-high reset
//  l_r_clk      I2S word select; rising edge starts a frame
//  bypass       1 = output captured input unfiltered (filters still run)
//  audio_in     signed input sample
//  coef_addr    coefficient index band*5+tap (0 outside MAC)
//  coef_data    coefficient for coef_addr, Q2.14, combinational read
//  audio_out    filtered sample, held until next result
//  out_valid    1-cycle pulse with new audio_out
//  busy         high whenever the FSM is not IDLE
//  overrun      1-cycle pulse when a start edge lands while busy
module eq_mac_scheduler
  import eq_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 40,
  parameter int NUM_BANDS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l_r_clk,
  input  logic              bypass,
  input  logic [DATA_W-1:0] audio_in,
  output logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [DATA_W-1:0] audio_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int PW = DATA_W + COEF_W;

  state_e                   state_q, state_d;
  logic [BW-1:0]            band_q, band_d;
  logic [2:0]               tap_q, tap_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] band_in_q, band_in_d;
  logic [DATA_W-1:0]        cap_q, cap_d;
  logic                     bypass_q, bypass_d;
  logic                     lrc_q, lrc_d;
  logic [DATA_W-1:0]        audio_out_q, audio_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  // Per-band history, indexed by band_q
  logic signed [DATA_W-1:0] x1_q [NUM_BANDS];
  logic signed [DATA_W-1:0] x2_q [NUM_BANDS];
  logic signed [DATA_W-1:0] y1_q [NUM_BANDS];
  logic signed [DATA_W-1:0] y2_q [NUM_BANDS];
  logic signed [DATA_W-1:0] x1_d [NUM_BANDS];
  logic signed [DATA_W-1:0] x2_d [NUM_BANDS];
  logic signed [DATA_W-1:0] y1_d [NUM_BANDS];
  logic signed [DATA_W-1:0] y2_d [NUM_BANDS];

  logic                     start;
  logic signed [DATA_W-1:0] opnd;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [DATA_W-1:0] y_rs;

  assign start     = l_r_clk & ~lrc_q;
  assign busy      = (state_q != IDLE);
  assign audio_out = audio_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign coef_addr = (state_q == MAC)
                   ? 4'(32'(band_q) * TAPS_PER_BAND + 32'(tap_q)) : 4'd0;

  // Single multiplier: operand chosen by tap, coefficient from the bank
  always_comb begin
    opnd = band_in_q;
    case (tap_q)
      3'd1:    opnd = x1_q[band_q];
      3'd2:    opnd = x2_q[band_q];
      3'd3:    opnd = y1_q[band_q];
      3'd4:    opnd = y2_q[band_q];
      default: opnd = band_in_q;
    endcase
  end

  assign prod     = opnd * $signed(coef_data);
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  eq_round_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_rs (
    .acc (acc_q),
    .y   (y_rs)
  );

  always_comb begin
    state_d     = state_q;
    band_d      = band_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    band_in_d   = band_in_q;
    cap_d       = cap_q;
    bypass_d    = bypass_q;
    lrc_d       = l_r_clk;
    audio_out_d = audio_out_q;
    out_valid_d = 1'b0;
    overrun_d   = start & (state_q != IDLE);
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    case (state_q)
      IDLE: if (start) state_d = CAPTURE;
      CAPTURE: begin
        band_in_d = audio_in;
        cap_d     = audio_in;
        bypass_d  = bypass;
        acc_d     = '0;
        band_d    = '0;
        tap_d     = '0;
        state_d   = MAC;
      end
      MAC: begin
        // feedback taps (a1, a2) subtract
        acc_d = (tap_q >= 3'd3) ? acc_q - prod_ext : acc_q + prod_ext;
        if (tap_q == 3'd4) begin
          tap_d   = '0;
          state_d = WB;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end
      WB: begin
        x2_d[band_q] = x1_q[band_q];
        x1_d[band_q] = band_in_q;
        y2_d[band_q] = y1_q[band_q];
        y1_d[band_q] = y_rs;
        band_in_d    = y_rs;
        acc_d        = '0;
        if (band_q == BW'(NUM_BANDS - 1)) begin
          state_d = DONE;
        end else begin
          band_d  = band_q + BW'(1);
          state_d = MAC;
        end
      end
      DONE: begin
        // band_in_q now holds the last band's output
        audio_out_d = bypass_q ? cap_q : band_in_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      band_q      <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      band_in_q   <= '0;
      cap_q       <= '0;
      bypass_q    <= 1'b0;
      lrc_q       <= 1'b0;
      audio_out_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        x1_q[b] <= '0;
        x2_q[b] <= '0;
        y1_q[b] <= '0;
        y2_q[b] <= '0;
      end
    end else begin
      state_q     <= state_d;
      band_q      <= band_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      band_in_q   <= band_in_d;
      cap_q       <= cap_d;
      bypass_q    <= bypass_d;
      lrc_q       <= lrc_d;
      audio_out_q <= audio_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
    end
  end

endmodule
